// File: rtl/spi_master_gen_pkg.sv
// spi_pkg: shared definitions for the spi_master_gen core.
//   spi_state_e       transfer FSM states (IDLE -> LEAD -> SHIFT -> TRAIL)
//   CPOL_BIT/CPHA_BIT bit positions inside the 2-bit mode word {CPOL,CPHA}
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_gen_if.sv
// spi_master_gen_if: host-side handshake bundle of the SPI primary core.
//   cs/rd/wr   host select, read strobe, write (start) strobe
//   din        transmit word          dout      last received word
//   mode       {CPOL,CPHA}            rx_valid  dout holds an unread word
//   ss_sel     secondary index        done      core idle / ready
// Modports: master = host driving requests, slave = the SPI core.
interface spi_master_gen_if #(
    parameter int DWIDTH = 8,
    parameter int SSW    = 1
);
    logic              cs;
    logic              rd;
    logic              wr;
    logic [DWIDTH-1:0] din;
    logic [1:0]        mode;
    logic [SSW-1:0]    ss_sel;
    logic [DWIDTH-1:0] dout;
    logic              rx_valid;
    logic              done;

    modport master (
        output cs, rd, wr, din, mode, ss_sel,
        input  dout, rx_valid, done
    );

    modport slave (
        input  cs, rd, wr, din, mode, ss_sel,
        output dout, rx_valid, done
    );
endinterface

// File: rtl/spi_master_gen_clkgen.sv
// spi_clkgen: half-period counter and SCLK edge pulse generator.
//   i_clk/i_rst   system clock, synchronous active-high reset
//   i_run         count while a transfer is active; held at 0 otherwise
//   i_shift       FSM is in SHIFT, so wraps are real SCLK edges
//   i_sclk/i_cpol current SCLK level and idle polarity of the transfer
//   o_tick        counter wraps this cycle (end of a half-period)
//   o_lead_edge   wrap that moves SCLK away from its idle level
//   o_trail_edge  wrap that returns SCLK to its idle level
module spi_clkgen #(
    parameter int CLKDIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_shift,
    input  logic i_sclk,
    input  logic i_cpol,
    output logic o_tick,
    output logic o_lead_edge,
    output logic o_trail_edge
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == CW'(CLKDIV - 1));

    // Counter sits at 0 while idle so the first LEAD half-period is full length.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Edge type is decided by where SCLK currently sits relative to CPOL.
    assign o_lead_edge  = o_tick && i_shift && (i_sclk == i_cpol);
    assign o_trail_edge = o_tick && i_shift && (i_sclk != i_cpol);
endmodule

// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised SPI primary with four CPOL/CPHA modes,
// configurable word width / SCLK divider and one-hot active-low selects.
//   clk, rst  system clock, synchronous active-high reset
//   bus       host handshake (spi_master_gen_if.slave)
//   sclk/mosi SPI clock and data out; miso SPI data in
//   ss_n      active-low secondary selects, one per secondary
// Optional: `define SPI_MASTER_LOOPBACK_EN adds input 'loopback'; when set at
// transfer start the receiver samples mosi and no ss_n line asserts.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int CLKDIV = 2,
    parameter int NSS    = 1,
    parameter int SSW    = (NSS > 1) ? $clog2(NSS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_master_gen_if.slave bus,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic            loopback,
`endif
    output logic [NSS-1:0]  ss_n
);
    localparam int HW = $clog2(2 * DWIDTH);

    spi_state_e        r_state, w_next;
    logic [1:0]        r_mode;
    logic [DWIDTH-1:0] r_tx, r_rx, r_dout;
    logic              r_rx_valid, r_sclk, r_mosi;
    logic [NSS-1:0]    r_ss_n, w_sel_n;
    logic [HW-1:0]     r_hcnt;
    logic              w_start, w_read, w_tick, w_lead, w_trail, w_last, w_sdi, w_sample;

    assign w_start = (r_state == IDLE) && bus.cs && bus.wr && !bus.rd;
    assign w_read  = bus.cs && bus.rd;
    assign w_last  = (r_hcnt == HW'(2 * DWIDTH - 1));

    spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (r_state != IDLE),
        .i_shift      (r_state == SHIFT),
        .i_sclk       (r_sclk),
        .i_cpol       (r_mode[CPOL_BIT]),
        .o_tick       (w_tick),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    logic r_lb;
    assign w_sdi = r_lb ? r_mosi : miso;
`else
    assign w_sdi = miso;
`endif

    // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge shifts.
    assign w_sample = r_mode[CPHA_BIT] ? w_trail : w_lead;

    // One-hot select decode; an out-of-range index leaves every line high.
    always_comb begin
        w_sel_n = '1;
        for (int i = 0; i < NSS; i++)
            if (int'(bus.ss_sel) == i) w_sel_n[i] = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        if (loopback) w_sel_n = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start)           w_next = LEAD;
            LEAD:    if (w_tick)            w_next = SHIFT;
            SHIFT:   if (w_tick && w_last)  w_next = TRAIL;
            TRAIL:   if (w_tick)            w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_dout     <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= '1;
            r_hcnt     <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_lb       <= 1'b0;
`endif
        end else begin
            if (w_read) r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_mode <= bus.mode;
                    r_sclk <= bus.mode[CPOL_BIT];
                    r_ss_n <= w_sel_n;
                    r_rx   <= '0;
                    r_hcnt <= '0;
                    // CPHA=0 needs the MSB on the wire before the first edge.
                    if (!bus.mode[CPHA_BIT]) begin
                        r_mosi <= bus.din[DWIDTH-1];
                        r_tx   <= {bus.din[DWIDTH-2:0], 1'b0};
                    end else begin
                        r_tx   <= bus.din;
                    end
`ifdef SPI_MASTER_LOOPBACK_EN
                    r_lb   <= loopback;
`endif
                end
                SHIFT: if (w_tick) begin
                    r_sclk <= ~r_sclk;
                    r_hcnt <= r_hcnt + 1'b1;
                    if (w_sample) begin
                        r_rx <= {r_rx[DWIDTH-2:0], w_sdi};
                    end else begin
                        r_mosi <= r_tx[DWIDTH-1];
                        r_tx   <= {r_tx[DWIDTH-2:0], 1'b0};
                    end
                end
                // Completion overrides a same-cycle read clear.
                TRAIL: if (w_tick) begin
                    r_ss_n     <= '1;
                    r_dout     <= r_rx;
                    r_rx_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.dout     = r_dout;
    assign bus.rx_valid = r_rx_valid;
    assign bus.done     = (r_state == IDLE);
    assign sclk         = r_sclk;
    assign mosi         = r_mosi;
    assign ss_n         = r_ss_n;
endmodule

// File: tb/tb_spi_master_gen.sv
module tb_spi_master_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // main DUT: 8-bit, CLKDIV=2, four secondaries, 3-bit select
    spi_master_gen_if #(.DWIDTH(8), .SSW(3)) bus ();
    logic       sclk, mosi, miso;
    logic [3:0] ss_n;
    logic       lb0 = 1'b0;

    spi_master_gen #(.DWIDTH(8), .CLKDIV(2), .NSS(4), .SSW(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(lb0),
`endif
        .ss_n(ss_n)
    );

    // smoke DUT: 16-bit, CLKDIV=1, loopback (internal or wired)
    spi_master_gen_if #(.DWIDTH(16), .SSW(1)) bus2 ();
    logic       sclk2, mosi2, miso2;
    logic [0:0] ss_n2;
    logic       lb1 = 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso2 = 1'b0;
`else
    assign miso2 = mosi2;
`endif

    spi_master_gen #(.DWIDTH(16), .CLKDIV(1), .NSS(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .sclk(sclk2), .mosi(mosi2), .miso(miso2),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(lb1),
`endif
        .ss_n(ss_n2)
    );

    // mode-aware shift-register secondary
    logic [7:0] s_reg, s_pre;
    logic [1:0] s_mode = 2'b00;
    logic       s_bit, s_miso, s_load = 1'b0;
    assign miso = s_mode[0] ? s_miso : s_reg[7];

    always @(posedge sclk or negedge sclk or posedge s_load) begin
        if (s_load) begin
            s_reg  <= s_pre;
            s_miso <= s_pre[7];
        end else if (sclk != s_mode[1]) begin
            if (!s_mode[0]) s_bit <= mosi;
            else begin
                s_miso <= s_reg[7];
                s_reg  <= {s_reg[6:0], 1'b0};
            end
        end else begin
            if (!s_mode[0]) s_reg <= {s_reg[6:0], s_bit};
            else            s_reg[0] <= mosi;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_slave(input logic [7:0] v, input logic [1:0] m);
        s_mode = m;
        s_pre  = v;
        s_load = 1'b1;
        #1;
        s_load = 1'b0;
    endtask

    task automatic start8(input logic [7:0] d, input logic [1:0] m, input logic [2:0] sel,
                          input logic [7:0] exp, input bit push);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
        bus.din = d; bus.mode = m; bus.ss_sel = sel;
        if (push) exp_q.push_back(exp);
        tick;
        bus.wr = 1'b0; bus.din = 8'h00;
    endtask

    task automatic wait_done8(input int wr_at, input int rd_at, input logic [3:0] ss_exp,
                              output int n);
        int ss_bad;
        logic [7:0] e;
        ss_bad = 0;
        n = 0;
        while (!bus.done && n < 200) begin
            if (ss_n !== ss_exp) ss_bad++;
            bus.wr  = (n == wr_at);
            bus.din = (n == wr_at) ? 8'hFF : 8'h00;
            bus.rd  = (n == rd_at);
            tick;
            n++;
        end
        bus.wr = 1'b0; bus.rd = 1'b0;
        total++;
        if (n >= 200) begin bad++; $display("FAIL done_timeout: waited %0d cycles", n); end
        total++;
        if (ss_bad != 0) begin bad++; $display("FAIL ss_active: %0d cycles differ from %b", ss_bad, ss_exp); end
        total++;
        if (ss_n !== 4'hF) begin bad++; $display("FAIL ss_idle: got %b want 1111", ss_n); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL scoreboard: empty queue at completion"); end
        else begin
            e = exp_q.pop_front();
            if (bus.dout !== e) begin bad++; $display("FAIL dout: got %h want %h", bus.dout, e); end
        end
    endtask

    task automatic test_reset;
        bus.cs = 0; bus.rd = 0; bus.wr = 0; bus.din = 0; bus.mode = 0; bus.ss_sel = 0;
        bus2.cs = 0; bus2.rd = 0; bus2.wr = 0; bus2.din = 0; bus2.mode = 0; bus2.ss_sel = 0;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rst_done: got %b want 1", bus.done); end
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", bus.dout); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rxv: got %b want 0", bus.rx_valid); end
        total++; if ({sclk, mosi} !== 2'b00) begin bad++; $display("FAIL rst_pins: got %b want 00", {sclk, mosi}); end
        total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL rst_ss: got %b want 1111", ss_n); end
    endtask

    task automatic test_reset_abort;
        start8(8'hA5, 2'b00, 3'd0, 8'h00, 1'b0);
        load_slave(8'h3C, 2'b00);
        repeat (17) tick;           // now inside SHIFT half-period 7
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL abort_done: got %b want 1", bus.done); end
        total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL abort_ss: got %b want 1111", ss_n); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL abort_dout: got %h want 00", bus.dout); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL abort_rxv: got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_mode0;
        int n;
        start8(8'hA5, 2'b00, 3'd0, 8'h3C, 1'b1);
        load_slave(8'h3C, 2'b00);
        wait_done8(-1, -1, 4'b1110, n);
        total++; if (n !== 36) begin bad++; $display("FAIL m0_latency: got %0d want 36", n); end
        total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL m0_rxv: got %b want 1", bus.rx_valid); end
        total++; if (s_reg !== 8'hA5) begin bad++; $display("FAIL m0_slave: got %h want a5", s_reg); end
    endtask

    task automatic test_modes;
        int n;
        for (int m = 1; m < 4; m++) begin
            start8(8'h81, 2'(m), 3'd0, 8'h7E, 1'b1);
            load_slave(8'h7E, 2'(m));
            total++; if (sclk !== 1'(m >> 1)) begin bad++; $display("FAIL mode%0d_lead_sclk: got %b want %b", m, sclk, 1'(m >> 1)); end
            wait_done8(-1, -1, 4'b1110, n);
            total++; if (n !== 36) begin bad++; $display("FAIL mode%0d_latency: got %0d want 36", m, n); end
            total++; if (s_reg !== 8'h81) begin bad++; $display("FAIL mode%0d_slave: got %h want 81", m, s_reg); end
            repeat (3) tick;
            total++; if (sclk !== 1'(m >> 1)) begin bad++; $display("FAIL mode%0d_idle_sclk: got %b want %b", m, sclk, 1'(m >> 1)); end
        end
    endtask

    task automatic test_ss;
        int n;
        start8(8'h11, 2'b00, 3'd2, 8'h5A, 1'b1);
        load_slave(8'h5A, 2'b00);
        wait_done8(-1, -1, 4'b1011, n);
        start8(8'h22, 2'b00, 3'd5, 8'hC3, 1'b1);
        load_slave(8'hC3, 2'b00);
        wait_done8(-1, -1, 4'b1111, n);
    endtask

    task automatic test_wr_ignored;
        int n;
        start8(8'hA5, 2'b00, 3'd0, 8'h3C, 1'b1);
        load_slave(8'h3C, 2'b00);
        wait_done8(10, -1, 4'b1110, n);
        total++; if (n !== 36) begin bad++; $display("FAIL wr_mid_latency: got %0d want 36", n); end
        total++; if (s_reg !== 8'hA5) begin bad++; $display("FAIL wr_mid_slave: got %h want a5", s_reg); end
    endtask

    task automatic test_back_to_back;
        int n;
        start8(8'h12, 2'b00, 3'd0, 8'h34, 1'b1);
        load_slave(8'h34, 2'b00);
        wait_done8(-1, 35, 4'b1110, n);   // rd lands on the completion edge
        total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_rd_race: got %b want 1", bus.rx_valid); end
        start8(8'h56, 2'b00, 3'd0, 8'h78, 1'b1);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_accept: got done=%b want 0", bus.done); end
        load_slave(8'h78, 2'b00);
        wait_done8(-1, -1, 4'b1110, n);
        total++; if (n !== 36) begin bad++; $display("FAIL b2b_latency: got %0d want 36", n); end
        total++; if (s_reg !== 8'h56) begin bad++; $display("FAIL b2b_slave: got %h want 56", s_reg); end
        bus.rd = 1'b1;
        tick;
        bus.rd = 1'b0;
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rd_clear: got %b want 0", bus.rx_valid); end
        repeat (4) tick;
        total++; if (bus.dout !== 8'h78) begin bad++; $display("FAIL dout_stable: got %h want 78", bus.dout); end
    endtask

    task automatic test_loopback;
        int n;
        bus2.cs = 1'b1; bus2.wr = 1'b1; bus2.din = 16'hBEEF; bus2.mode = 2'b00;
        tick;
        bus2.wr = 1'b0;
        n = 0;
        while (!bus2.done && n < 200) begin tick; n++; end
        total++; if (n !== 34) begin bad++; $display("FAIL lb_latency: got %0d want 34", n); end
        total++; if (bus2.dout !== 16'hBEEF) begin bad++; $display("FAIL lb_dout: got %h want beef", bus2.dout); end
        total++; if (bus2.rx_valid !== 1'b1) begin bad++; $display("FAIL lb_rxv: got %b want 1", bus2.rx_valid); end
    endtask

    initial begin
        test_reset;
        test_reset_abort;
        test_mode0;
        test_modes;
        test_ss;
        test_wr_ignored;
        test_back_to_back;
        test_loopback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
